acc_fm_writer: RTL and testbench
================================

# acc_fm_writer

Write-back stage downstream of the accumulate/bias/ReLU stage. Receives its 8-bit-per-channel result beats (`valid` plus a per-channel-group `end` pulse) and turns them into word writes to the output feature-map buffer. Packs two 16-channel beats into one 256-bit word outside layer 1, generates linear write addresses and byte masks, and signals layer completion. There is no back-pressure toward the upstream stage; every beat must be accepted on the cycle it is valid.

## Interface
- `DW`, 256: beat / write-word width (32 channels x 8 bit)
- `AW`, 16: write address width
- `clk` input 1: clock, rising edge
- `rst_n` input 1: asynchronous active-low reset
- `layer1` input 1: 1 = 32-channel beats (no packing); 0 = 16-channel beats in `i_acc_data[127:0]`, packed in pairs
- `i_start` input 1: one-cycle pulse; latches configuration and starts a layer (honoured in IDLE only)
- `i_wr_addr_base` input AW: first write address of the layer
- `i_fm_col` input 16: beats per row, >=1
- `i_grp_num` input 8: `i_acc_end` pulses per layer, >=1
- `i_acc_data` input DW: result beat
- `i_acc_data_valid` input 1: beat valid
- `i_acc_end` input 1: end of one channel group
- `o_wr_en` output 1: buffer write strobe
- `o_wr_addr` output AW: write address
- `o_wr_data` output DW: write data
- `o_wr_mask` output 32: byte enables, bit k covers `o_wr_data[8k+7:8k]`
- `o_busy` output 1: state != IDLE
- `o_layer_done` output 1: one-cycle completion pulse
- `o_err` output 1: sticky protocol error, cleared only by reset

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN: on `i_start`. Latch `i_wr_addr_base` into the address counter, latch `i_fm_col` and `i_grp_num`, clear the column counter, group counter and half-word pending flag.
  - RUN to DONE: when an `i_acc_end` brings the group count to `i_grp_num`.
  - DONE to IDLE: unconditionally after one cycle.
  - `i_start` outside IDLE is ignored.
- Column counter: increments on each valid beat. At `i_fm_col-1` it wraps to 0, which marks a row end. It also clears on `i_acc_end`.
- `layer1`=1: every beat produces one write.
  - `o_wr_data` = beat, mask = 32'hFFFFFFFF.
- `layer1`=0, beat is not a row end and no half is pending: store `beat[127:0]` as the low half, set pending. No write.
- `layer1`=0, beat with a half pending: write {`beat[127:0]`, stored low half}, mask 32'hFFFFFFFF, clear pending.
- `layer1`=0, row-end beat with no half pending: write {128'b0, `beat[127:0]`}, mask 32'h0000FFFF. Odd `i_fm_col` therefore yields one half word per row.
- `i_acc_end` with a half pending: flush it as a half word (mask 32'h0000FFFF) and clear pending.
- `i_acc_end` increments the group counter.
- The address counter increments by 1 after every write and wraps from 16'hFFFF to 16'h0000.
- Valid beat in the same cycle as `i_acc_end`: the beat is processed first, then the end. If that beat leaves a half pending, the half is flushed in the same cycle.
- `i_acc_data_valid` or `i_acc_end` in IDLE or DONE: input dropped, `o_err` set.
- `layer1` is sampled per beat and must stay stable for a whole layer. Changing it mid-layer is unsupported.

## Timing
- Reset values: `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_wr_mask`=0, `o_busy`=0, `o_layer_done`=0, `o_err`=0, state IDLE. Reset mid-layer discards any pending half and all counts.
- All outputs are registered.
- A write appears exactly 1 cycle after the beat (or `i_acc_end`) that triggers it. `o_wr_en` is high for 1 cycle per write.
- `o_busy` rises 1 cycle after `i_start`.
- `o_layer_done` is high during the DONE cycle, 1 cycle after the final `i_acc_end`. Any flush write from that end appears in the same cycle as `o_layer_done`.
- `o_busy` falls 1 cycle after `o_layer_done`.
- Throughput: 1 beat per cycle sustained, back-to-back valid with no gaps.

## Test plan
- Layer-1, base=16'h0100, fm_col=4, grp_num=1, 4 back-to-back beats then end: 4 writes at 0x0100..0x0103, each with full mask and data equal to its beat; `o_layer_done` 1 cycle after end; `o_err`=0.
- Packed, base=0, fm_col=4, beats A, B, C, D, then end: 2 writes.
  - addr 0 = {B[127:0], A[127:0]}, mask FFFFFFFF.
  - addr 1 = {D[127:0], C[127:0]}, mask FFFFFFFF.
- Packed, fm_col=3, 2 rows: 4 writes with masks FFFFFFFF, 0000FFFF, FFFFFFFF, 0000FFFF at addresses 0..3.
- Packed, fm_col=4, grp_num=2, 3 beats then end carried on the 3rd beat: half-word flush with mask 0000FFFF; `o_layer_done` does not fire until the 2nd end.
- Base=16'hFFFF, layer1, 2 beats: writes at FFFF then 0000.
- Misuse and reset:
  - Valid beat in IDLE: no write, `o_err`=1 and remains set after a subsequent normal layer.
  - Async reset asserted mid-row: all outputs go to their reset values immediately; after a new `i_start` the layer writes from the new base with no stale half word.

Source files
------------

// File: rtl/acc_fm_writer.sv
// Write-back stage: turns accumulate/bias/ReLU result beats into output feature-map
// buffer writes, packing 16-channel beats in pairs outside layer 1.
module acc_fm_writer #(
  parameter int DW = 256,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          layer1,
  input  logic          i_start,
  input  logic [AW-1:0] i_wr_addr_base,
  input  logic [15:0]   i_fm_col,
  input  logic [7:0]    i_grp_num,
  input  logic [DW-1:0] i_acc_data,
  input  logic          i_acc_data_valid,
  input  logic          i_acc_end,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic [31:0]   o_wr_mask,
  output logic          o_busy,
  output logic          o_layer_done,
  output logic          o_err,
  output logic [1:0]    o_dbg_state
);

  localparam int HW = DW / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   fm_col_q, fm_col_d;
  logic [15:0]   col_q, col_d;
  logic [7:0]    grp_num_q, grp_num_d;
  logic [7:0]    grp_q, grp_d;
  logic          pend_q, pend_d;
  logic [HW-1:0] low_q, low_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [31:0]   wr_mask_q, wr_mask_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          row_end;

  // Upstream has no ready: a beat or end pulse is consumed in the cycle its strobe is
  // high; strobes arriving outside RUN are dropped and latch the sticky error.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    fm_col_d  = fm_col_q;
    col_d     = col_q;
    grp_num_d = grp_num_q;
    grp_d     = grp_q;
    pend_d    = pend_q;
    low_d     = low_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    err_d     = err_q;
    row_end   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_acc_data_valid || i_acc_end) err_d = 1'b1;
        if (i_start) begin
          state_d   = S_RUN;
          addr_d    = i_wr_addr_base;
          fm_col_d  = i_fm_col;
          grp_num_d = i_grp_num;
          col_d     = 16'd0;
          grp_d     = 8'd0;
          pend_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (i_acc_data_valid) begin
          row_end = (col_q == fm_col_q - 16'd1);
          col_d   = row_end ? 16'd0 : col_q + 16'd1;
          if (layer1) begin
            wr_en_d   = 1'b1;
            wr_data_d = i_acc_data;
            wr_mask_d = 32'hFFFF_FFFF;
          end else if (pend_q) begin
            wr_en_d   = 1'b1;
            wr_data_d = {i_acc_data[HW-1:0], low_q};
            wr_mask_d = 32'hFFFF_FFFF;
            pend_d    = 1'b0;
          end else if (row_end) begin
            wr_en_d   = 1'b1;
            wr_data_d = {{HW{1'b0}}, i_acc_data[HW-1:0]};
            wr_mask_d = 32'h0000_FFFF;
          end else begin
            low_d  = i_acc_data[HW-1:0];
            pend_d = 1'b1;
          end
        end
        // A half left pending (possibly by this very beat) never coexists with a beat write.
        if (i_acc_end) begin
          col_d = 16'd0;
          grp_d = grp_q + 8'd1;
          if (pend_d) begin
            wr_en_d   = 1'b1;
            wr_data_d = {{HW{1'b0}}, low_d};
            wr_mask_d = 32'h0000_FFFF;
            pend_d    = 1'b0;
          end
          if (grp_d == grp_num_q) state_d = S_DONE;
        end
        if (wr_en_d) begin
          wr_addr_d = addr_q;
          addr_d    = addr_q + AW'(1);
        end
      end
      S_DONE: begin
        if (i_acc_data_valid || i_acc_end) err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      fm_col_q  <= '0;
      col_q     <= '0;
      grp_num_q <= '0;
      grp_q     <= '0;
      pend_q    <= 1'b0;
      low_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      fm_col_q  <= fm_col_d;
      col_q     <= col_d;
      grp_num_q <= grp_num_d;
      grp_q     <= grp_d;
      pend_q    <= pend_d;
      low_q     <= low_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_wr_mask    = wr_mask_q;
  assign o_busy       = busy_q;
  assign o_layer_done = done_q;
  assign o_err        = err_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_acc_fm_writer.sv
// Self-checking bench for acc_fm_writer: a reference model fills a write scoreboard and a
// per-cycle control queue as stimulus is driven; a monitor pops and compares DUT outputs.
module tb_acc_fm_writer;

  localparam int DW = 256;
  localparam int AW = 16;
  localparam int EW = AW + 32 + DW;

  logic          clk;
  logic          rst_n;
  logic          layer1;
  logic          i_start;
  logic [AW-1:0] i_wr_addr_base;
  logic [15:0]   i_fm_col;
  logic [7:0]    i_grp_num;
  logic [DW-1:0] i_acc_data;
  logic          i_acc_data_valid;
  logic          i_acc_end;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic [31:0]   o_wr_mask;
  logic          o_busy;
  logic          o_layer_done;
  logic          o_err;
  logic [1:0]    o_dbg_state;

  acc_fm_writer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .layer1(layer1), .i_start(i_start),
    .i_wr_addr_base(i_wr_addr_base), .i_fm_col(i_fm_col), .i_grp_num(i_grp_num),
    .i_acc_data(i_acc_data), .i_acc_data_valid(i_acc_data_valid), .i_acc_end(i_acc_end),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_mask(o_wr_mask),
    .o_busy(o_busy), .o_layer_done(o_layer_done), .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];   // {addr, mask, data} of each expected write
  logic [3:0]    ctl_q[$];   // per cycle {wr_en, layer_done, busy, err}

  task automatic check_eq(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  int             m_state;   // 0 idle, 1 run, 2 done
  logic [AW-1:0]  m_addr;
  logic [15:0]    m_fm_col;
  logic [15:0]    m_col;
  logic [7:0]     m_grp_num;
  logic [7:0]     m_grp;
  logic           m_pend;
  logic [127:0]   m_low;
  logic           m_err;

  task automatic model_reset();
    m_state = 0; m_addr = '0; m_fm_col = '0; m_col = '0;
    m_grp_num = '0; m_grp = '0; m_pend = 1'b0; m_low = '0; m_err = 1'b0;
  endtask

  // driver: one call per cycle, inputs change on the falling edge
  task automatic drive(input logic v, input logic e, input logic [DW-1:0] d, input logic s);
    logic          w;
    logic          re;
    logic [31:0]   wm;
    logic [DW-1:0] wd;
    @(negedge clk);
    i_acc_data_valid = v;
    i_acc_end        = e;
    i_acc_data       = d;
    i_start          = s;
    w = 1'b0; wm = '0; wd = '0;
    case (m_state)
      0: begin
        if (v || e) m_err = 1'b1;
        if (s) begin
          m_state = 1; m_addr = i_wr_addr_base; m_fm_col = i_fm_col;
          m_grp_num = i_grp_num; m_col = '0; m_grp = '0; m_pend = 1'b0;
        end
      end
      1: begin
        if (v) begin
          re = (m_col == m_fm_col - 16'd1);
          m_col = re ? 16'd0 : m_col + 16'd1;
          if (layer1) begin
            w = 1'b1; wd = d; wm = 32'hFFFFFFFF;
          end else if (m_pend) begin
            w = 1'b1; wd = {d[127:0], m_low}; wm = 32'hFFFFFFFF; m_pend = 1'b0;
          end else if (re) begin
            w = 1'b1; wd = {128'b0, d[127:0]}; wm = 32'h0000FFFF;
          end else begin
            m_low = d[127:0]; m_pend = 1'b1;
          end
        end
        if (e) begin
          m_col = '0;
          m_grp = m_grp + 8'd1;
          if (m_pend) begin
            w = 1'b1; wd = {128'b0, m_low}; wm = 32'h0000FFFF; m_pend = 1'b0;
          end
          if (m_grp == m_grp_num) m_state = 2;
        end
      end
      default: begin
        if (v || e) m_err = 1'b1;
        m_state = 0;
      end
    endcase
    if (w) begin
      exp_q.push_back({m_addr, wm, wd});
      m_addr = m_addr + 16'd1;
    end
    ctl_q.push_back({w, m_state == 2, m_state != 0, m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic start_layer(input logic l1, input logic [AW-1:0] base,
                             input logic [15:0] cols, input logic [7:0] grps);
    @(negedge clk);
    layer1 = l1; i_wr_addr_base = base; i_fm_col = cols; i_grp_num = grps;
    drive(1'b0, 1'b0, '0, 1'b1);
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] b;
    for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, rnd_beat(), 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wr_en"}, EW'(o_wr_en), EW'(1'b0));
    check_eq({tag, "_wr_addr"}, EW'(o_wr_addr), EW'(0));
    check_eq({tag, "_wr_data"}, EW'(o_wr_data), EW'(0));
    check_eq({tag, "_wr_mask"}, EW'(o_wr_mask), EW'(0));
    check_eq({tag, "_busy"}, EW'(o_busy), EW'(1'b0));
    check_eq({tag, "_done"}, EW'(o_layer_done), EW'(1'b0));
    check_eq({tag, "_err"}, EW'(o_err), EW'(1'b0));
    check_eq({tag, "_state"}, EW'(o_dbg_state), EW'(0));
  endtask

  // scoreboard / monitor: samples 2 time units after each rising edge
  always @(posedge clk) begin
    logic [3:0]    c;
    logic [EW-1:0] x;
    #2;
    if (rst_n && ctl_q.size() > 0) begin
      c = ctl_q.pop_front();
      check_eq("wr_en", EW'(o_wr_en), EW'(c[3]));
      check_eq("layer_done", EW'(o_layer_done), EW'(c[2]));
      check_eq("busy", EW'(o_busy), EW'(c[1]));
      check_eq("err", EW'(o_err), EW'(c[0]));
      if (o_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL write_unexpected: got write at addr %0h expected none", o_wr_addr);
        end else begin
          x = exp_q.pop_front();
          check_eq("wr_addr", EW'(o_wr_addr), EW'(x[EW-1 -: AW]));
          check_eq("wr_mask", EW'(o_wr_mask), EW'(x[DW +: 32]));
          check_eq("wr_data", EW'(o_wr_data), EW'(x[DW-1:0]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; layer1 = 1'b0; i_start = 1'b0; i_wr_addr_base = '0; i_fm_col = 16'd1;
    i_grp_num = 8'd1; i_acc_data = '0; i_acc_data_valid = 1'b0; i_acc_end = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // layer 1, base 0x0100, four beats, separate end; a stray start mid-layer is ignored
    start_layer(1'b1, 16'h0100, 16'd4, 8'd1);
    beats(2);
    drive(1'b1, 1'b0, rnd_beat(), 1'b1);
    beats(1);
    drive(1'b0, 1'b1, '0, 1'b0);
    idle(3);

    // packed, even row: two full words
    start_layer(1'b0, 16'h0000, 16'd4, 8'd1);
    beats(4);
    drive(1'b0, 1'b1, '0, 1'b0);
    idle(3);

    // packed, odd row of 3, two rows: full / half / full / half
    start_layer(1'b0, 16'h0000, 16'd3, 8'd1);
    beats(6);
    drive(1'b0, 1'b1, '0, 1'b0);
    idle(3);

    // packed, two groups; first end rides on the third beat and flushes a half
    start_layer(1'b0, 16'h0000, 16'd4, 8'd2);
    beats(2);
    drive(1'b1, 1'b1, rnd_beat(), 1'b0);
    idle(2);
    beats(3);
    drive(1'b0, 1'b1, '0, 1'b0);
    idle(3);

    // address wrap from 0xFFFF
    start_layer(1'b1, 16'hFFFF, 16'd2, 8'd1);
    beats(2);
    drive(1'b0, 1'b1, '0, 1'b0);
    idle(3);

    // misuse: beat and end in IDLE set a sticky error that survives a normal layer
    drive(1'b1, 1'b0, rnd_beat(), 1'b0);
    idle(1);
    drive(1'b0, 1'b1, '0, 1'b0);
    start_layer(1'b0, 16'h0020, 16'd2, 8'd1);
    beats(2);
    drive(1'b0, 1'b1, '0, 1'b0);
    drive(1'b1, 1'b0, rnd_beat(), 1'b0);
    idle(3);

    // async reset mid-row with a half pending, then a fresh layer from a new base
    start_layer(1'b0, 16'h0300, 16'd4, 8'd1);
    beats(3);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    ctl_q.delete();
    model_reset();
    i_acc_data_valid = 1'b0; i_acc_end = 1'b0; i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_layer(1'b0, 16'h0040, 16'd2, 8'd1);
    beats(2);
    drive(1'b0, 1'b1, '0, 1'b0);
    idle(4);

    check_eq("exp_q_empty", EW'(exp_q.size()), EW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
